// File: rtl/noc_ingress_buffer.sv
// Ingress flit buffer: filters invalid control codes, queues data flits and routes the head
// either to the next hop unmodified or to the local bucket after single-error correction.
module noc_ingress_buffer #(
  parameter int         DEPTH   = 4,
  parameter logic [3:0] NODE_ID = 4'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [10:0]              in_data,
  input  logic [1:0]               in_ctrl,
  output logic                     fwd_valid,
  input  logic                     fwd_ready,
  output logic [10:0]              fwd_data,
  output logic                     local_valid,
  input  logic                     local_ready,
  output logic [10:0]              local_data,
  output logic [7:0]               err_count,
  output logic [7:0]               drop_count,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    err_q, err_d, drop_q, drop_d;
  logic          rdy_en_q;

  logic [10:0] head, flip;
  logic [2:0]  syn;
  logic        non_empty, is_local, accept, push, pop, local_xfer;

  assign head      = mem_q[rd_ptr_q];
  assign non_empty = (count_q != '0);
  assign is_local  = (head[3:0] == NODE_ID);

  // rdy_en_q keeps in_ready low while reset is held and for the cycle it releases
  assign in_ready    = rdy_en_q && (count_q < CW'(DEPTH));
  assign fwd_valid   = non_empty && !is_local;
  assign local_valid = non_empty && is_local;

  assign syn = {head[7] ^ head[8] ^ head[9] ^ head[10],
                head[5] ^ head[6] ^ head[9] ^ head[10],
                head[4] ^ head[6] ^ head[8] ^ head[10]};
  assign flip       = (syn != 3'd0) ? (11'd1 << (4'(syn) + 4'd3)) : 11'd0;
  assign fwd_data   = head;
  assign local_data = head ^ flip;

  assign accept     = in_valid && in_ready;
  assign push       = accept && (in_ctrl == 2'd2);
  assign local_xfer = local_valid && local_ready;
  assign pop        = (fwd_valid && fwd_ready) || local_xfer;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
    drop_d   = drop_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (!push && pop)
      count_d = count_q - 1'b1;
    if (push)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)
      rd_ptr_d = rd_ptr_q + 1'b1;
    if (local_xfer && (syn != 3'd0) && (err_q != 8'hFF))
      err_d = err_q + 8'd1;
    if (accept && (in_ctrl != 2'd2) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= '0;
      drop_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read once count_q covers it
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= in_data;
  end

  assign err_count  = err_q;
  assign drop_count = drop_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_noc_ingress_buffer.sv
// Bench for noc_ingress_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_noc_ingress_buffer;

  localparam int         DEPTH = 4;
  localparam logic [3:0] NID   = 4'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_data = '0;
  logic [1:0]  in_ctrl = '0;
  logic        fwd_valid, local_valid;
  logic        fwd_ready = 1'b0;
  logic        local_ready = 1'b0;
  logic [10:0] fwd_data, local_data;
  logic [7:0]  err_count, drop_count;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  logic [10:0] mq[$];
  int          m_err, m_drop;
  bit          m_rdy;
  logic [10:0] plog[$];
  bit          log_en = 1'b0;
  bit          chk_on = 1'b0;

  noc_ingress_buffer #(.DEPTH(DEPTH), .NODE_ID(NID)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
    .local_valid(local_valid), .local_ready(local_ready), .local_data(local_data),
    .err_count(err_count), .drop_count(drop_count), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Payload bit (3+p) is Hamming position p; the syndrome is the XOR of set positions.
  function automatic int syndrome(input logic [10:0] f);
    int s = 0;
    for (int p = 1; p <= 7; p++)
      if (f[3+p]) s ^= p;
    return s;
  endfunction

  function automatic logic [10:0] corrected(input logic [10:0] f);
    logic [10:0] r = f;
    int s = syndrome(f);
    if (s != 0) r[3+s] = ~r[3+s];
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_err  = 0;
      m_drop = 0;
      m_rdy  = 1'b0;
    end else begin : step
      bit          pop, acc;
      logic [10:0] h;
      pop = 1'b0;
      if (mq.size() > 0) begin
        h = mq[0];
        if (h[3:0] == NID) begin
          if (local_ready) begin
            pop = 1'b1;
            if (syndrome(h) != 0 && m_err < 255) m_err++;
          end
        end else begin
          pop = fwd_ready;
        end
      end
      acc = in_valid && m_rdy && (mq.size() < DEPTH);
      if (pop) void'(mq.pop_front());
      if (acc) begin
        if (in_ctrl == 2'd2) mq.push_back(in_data);
        else if (m_drop < 255) m_drop++;
      end
      m_rdy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", 32'(in_ready), 32'(m_rdy && (mq.size() < DEPTH)));
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("err_count", 32'(err_count), 32'(m_err));
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      chk("fwd_valid", 32'(fwd_valid), 32'(mq.size() > 0 && mq[0][3:0] != NID));
      chk("local_valid", 32'(local_valid), 32'(mq.size() > 0 && mq[0][3:0] == NID));
      if (mq.size() > 0 && mq[0][3:0] != NID) chk("fwd_data", 32'(fwd_data), 32'(mq[0]));
      if (mq.size() > 0 && mq[0][3:0] == NID) chk("local_data", 32'(local_data), 32'(corrected(mq[0])));
    end
  end

  always @(negedge clk) begin
    if (log_en && !reset) begin
      if (fwd_valid && fwd_ready) plog.push_back(fwd_data);
      if (local_valid && local_ready) plog.push_back(local_data);
    end
  end

  task automatic send(input logic [10:0] d, input logic [1:0] c);
    bit done = 1'b0;
    in_data  = d;
    in_ctrl  = c;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    #2 reset = 1'b0;
    chk_on = 1'b1;
    #1 chk("post_rst_in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // clean local flit
    fwd_ready = 1'b1; local_ready = 1'b1;
    send(11'h525, 2'd2);
    chk("clean_local_valid", 32'(local_valid), 32'd1);
    chk("clean_local_data", 32'(local_data), 32'h525);
    chk("clean_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("clean_err", 32'(err_count), 32'd0);

    // single-bit error on payload bit 6
    send(11'h565, 2'd2);
    chk("corr_local_data", 32'(local_data), 32'h525);
    @(posedge clk); #1;
    chk("corr_err", 32'(err_count), 32'd1);

    // forwarded flit passes unmodified
    send(11'h523, 2'd2);
    chk("fwd_data_lit", 32'(fwd_data), 32'h523);
    chk("fwd_local_valid", 32'(local_valid), 32'd0);
    @(posedge clk); #1;
    chk("fwd_err_unchanged", 32'(err_count), 32'd1);
    fwd_ready = 1'b0; local_ready = 1'b0;

    // fill, block the fifth, then drain in order
    send(11'h525, 2'd2);
    send(11'h523, 2'd2);
    send(11'h565, 2'd2);
    send(11'h521, 2'd2);
    in_data = 11'h1A7; in_ctrl = 2'd2; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(fifo_count), 32'd4);
    @(posedge clk); #1;
    plog.delete();
    log_en = 1'b1;
    fwd_ready = 1'b1; local_ready = 1'b1;
    send(11'h1A7, 2'd2);
    repeat (8) @(posedge clk);
    #1;
    log_en = 1'b0;
    chk("drain_len", 32'(plog.size()), 32'd5);
    if (plog.size() == 5) begin
      chk("drain0", 32'(plog[0]), 32'h525);
      chk("drain1", 32'(plog[1]), 32'h523);
      chk("drain2", 32'(plog[2]), 32'h525);
      chk("drain3", 32'(plog[3]), 32'h521);
      chk("drain4", 32'(plog[4]), 32'h1A7);
    end
    chk("drain_err", 32'(err_count), 32'd2);
    chk("drain_count", 32'(fifo_count), 32'd0);

    // invalid control codes
    send(11'h525, 2'd0);
    send(11'h525, 2'd3);
    chk("drop_two", 32'(drop_count), 32'd2);
    chk("drop_fifo", 32'(fifo_count), 32'd0);
    for (int i = 0; i < 298; i++) send(11'(i), 2'(i % 2));
    chk("drop_sat", 32'(drop_count), 32'hFF);

    // reset while holding three flits and offering a fourth
    fwd_ready = 1'b0; local_ready = 1'b0;
    send(11'h523, 2'd2);
    send(11'h525, 2'd2);
    send(11'h521, 2'd2);
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    in_data = 11'h52A; in_ctrl = 2'd2; in_valid = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_in_ready", 32'(in_ready), 32'd0);
    chk("async_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("async_local_valid", 32'(local_valid), 32'd0);
    chk("async_count", 32'(fifo_count), 32'd0);
    chk("async_err", 32'(err_count), 32'd0);
    chk("async_drop", 32'(drop_count), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("rerst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rerst_in_ready_high", 32'(in_ready), 32'd1);
    fwd_ready = 1'b1; local_ready = 1'b1;
    send(11'h565, 2'd2);
    chk("rerst_local_valid", 32'(local_valid), 32'd1);
    chk("rerst_local_data", 32'(local_data), 32'h525);
    @(posedge clk); #1;
    chk("rerst_err", 32'(err_count), 32'd1);
    chk("rerst_count", 32'(fifo_count), 32'd0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
